// File: rtl/disp_src_seq_if.sv
// Handshake bundle between the display sequencer and its neighbours.
// The sequencer takes the slave view. Upstream sources and the display driver take the master view.
interface disp_src_seq_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic                   tick;
    logic                   btn_next;
    logic                   btn_hold;
    logic                   auto_en;
    logic [NCH*WIDTH-1:0]   ch_data;
    logic [NCH-1:0]         ch_valid;
    logic [WIDTH-1:0]       disp_num;
    logic [SELW-1:0]        ch_sel;
    logic                   held;
    logic                   auto_on;

    modport master (
        output tick, btn_next, btn_hold, auto_en, ch_data, ch_valid,
        input  disp_num, ch_sel, held, auto_on
    );

    modport slave (
        input  tick, btn_next, btn_hold, auto_en, ch_data, ch_valid,
        output disp_num, ch_sel, held, auto_on
    );
endinterface

// File: rtl/disp_src_seq.sv
// Display-source sequencer: picks one of NCH channels for the 7-segment path.
// Channels change on button edges or by timed auto-rotation, and a hold mode freezes the shown value.
module disp_src_seq #(
    parameter int WIDTH     = 16,
    parameter int NCH       = 4,
    parameter int SELW      = 2,
    parameter int ROT_TICKS = 3
) (
    input  logic             clk,
    input  logic             rst,
    disp_src_seq_if.slave    bus
);
    localparam int CW = (ROT_TICKS > 1) ? $clog2(ROT_TICKS) : 1;

    typedef enum logic [1:0] {
        LIVE = 2'd0,
        AUTO = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e            state_q;
    logic [SELW-1:0]   ch_sel_q;
    logic [WIDTH-1:0]  disp_q;
    logic [CW-1:0]     rot_q;
    logic              held_q;
    logic              auto_on_q;
    logic              prev_next_q;
    logic              prev_hold_q;

    logic              next_e;
    logic              hold_e;
    logic [SELW-1:0]   sel_adv_d;
    logic [WIDTH-1:0]  disp_d;

    assign next_e = bus.btn_next & ~prev_next_q;
    assign hold_e = bus.btn_hold & ~prev_hold_q;

    // Scanning the largest offset first lets the nearest valid channel win.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        sel_adv_d = ch_sel_q;
        for (int k = 0; k < NCH; k++) begin
            if (SELW'(k) == ch_sel_q) begin
                for (int i = NCH - 1; i >= 1; i--) begin
                    if (bus.ch_valid[(k + i) % NCH]) begin
                        sel_adv_d = SELW'((k + i) % NCH);
                    end
                end
            end
        end
    end

    always_comb begin
        disp_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (SELW'(k) == ch_sel_q && bus.ch_valid[k]) begin
                disp_d = bus.ch_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments, so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset clears every register, and the edge detectors load the live button levels.
        if (rst) begin
            state_q     <= LIVE;
            ch_sel_q    <= '0;
            disp_q      <= '0;
            rot_q       <= '0;
            held_q      <= 1'b0;
            auto_on_q   <= 1'b0;
            prev_next_q <= bus.btn_next;
            prev_hold_q <= bus.btn_hold;
        end else begin
            prev_next_q <= bus.btn_next;
            prev_hold_q <= bus.btn_hold;

            if (state_q != HOLD) begin
                disp_q <= disp_d;
            end

            unique case (state_q)
                LIVE: begin
                    if (hold_e) begin
                        state_q <= HOLD;
                        held_q  <= 1'b1;
                    end else if (bus.auto_en) begin
                        state_q   <= AUTO;
                        auto_on_q <= 1'b1;
                        rot_q     <= '0;
                    end else if (next_e) begin
                        ch_sel_q <= sel_adv_d;
                    end
                end
                AUTO: begin
                    if (hold_e) begin
                        state_q   <= HOLD;
                        held_q    <= 1'b1;
                        auto_on_q <= 1'b0;
                    end else if (!bus.auto_en) begin
                        state_q   <= LIVE;
                        auto_on_q <= 1'b0;
                    end else if (next_e) begin
                        ch_sel_q <= sel_adv_d;
                        rot_q    <= '0;
                    end else if (bus.tick) begin
                        if (rot_q == CW'(ROT_TICKS - 1)) begin
                            ch_sel_q <= sel_adv_d;
                            rot_q    <= '0;
                        end else begin
                            rot_q <= rot_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_e) begin
                        rot_q  <= '0;
                        held_q <= 1'b0;
                        if (bus.auto_en) begin
                            state_q   <= AUTO;
                            auto_on_q <= 1'b1;
                        end else begin
                            state_q <= LIVE;
                        end
                    end
                end
                default: begin
                    state_q   <= LIVE;
                    held_q    <= 1'b0;
                    auto_on_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.disp_num = disp_q;
    assign bus.ch_sel   = ch_sel_q;
    assign bus.held     = held_q;
    assign bus.auto_on  = auto_on_q;
endmodule
